// File: rtl/ula_multiciclo_pkg.sv
// ----------------------------------------------------------------------------
// ula_multiciclo_pkg
// Shared definitions for the multi-cycle ALU and the ALU control unit that
// feeds it.
//   alu_op_e  : 4-bit ALUControl codes. Codes 1100-1111 are left undefined and
//               the datapath treats them as ADD.
//   state_e   : sequencer states of the multi-cycle ALU.
//   isShiftOp : true for the codes that go through the bit-serial shifter.
// ----------------------------------------------------------------------------
package ula_multiciclo_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_NOR  = 4'b0101,
        OP_SLT  = 4'b0110,
        OP_SLTU = 4'b0111,
        OP_SLL  = 4'b1000,
        OP_SRL  = 4'b1001,
        OP_SRA  = 4'b1010,
        OP_LUI  = 4'b1011
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Shifts are the only operations that take more than one cycle.
    function automatic logic isShiftOp(input logic [3:0] ctrl);
        return (ctrl == OP_SLL) || (ctrl == OP_SRL) || (ctrl == OP_SRA);
    endfunction

endpackage

// File: rtl/ula_comb.sv
// ----------------------------------------------------------------------------
// ula_comb
// Single-cycle combinational datapath of the multi-cycle ALU. It covers every
// operation that finishes in one cycle, and it computes signed overflow for
// ADD and SUB.
//   i_ctrl     : ALUControl code (alu_op_e values; 1100-1111 behave as ADD)
//   i_a, i_b   : operands
//   o_result   : operation result, wrapping modulo 2^WIDTH
//   o_overflow : signed overflow for ADD/SUB (and the undefined codes that
//                alias ADD); 0 for every other code
// For shift codes the result is simply i_b. That is the correct answer for a
// shift amount of zero, which is the only shift case the sequencer takes from
// here.
// ----------------------------------------------------------------------------
module ula_comb
    import ula_multiciclo_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int LUI_SH = WIDTH / 2
) (
    input  logic [3:0]       i_ctrl,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_overflow
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_addOvf;
    logic             w_subOvf;
    logic             w_lessSigned;
    logic             w_lessUnsigned;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;

    // Add overflows when both operands share a sign that the sum does not.
    // Subtract overflows when the operand signs differ and the difference
    // takes the sign of b instead of a.
    assign w_addOvf = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1]  != i_a[WIDTH-1]);
    assign w_subOvf = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);

    assign w_lessSigned   = $signed(i_a) < $signed(i_b);
    assign w_lessUnsigned = i_a < i_b;

    always_comb begin
        o_result   = w_sum;
        o_overflow = 1'b0;
        case (i_ctrl)
            OP_ADD:  begin o_result = w_sum;  o_overflow = w_addOvf; end
            OP_SUB:  begin o_result = w_diff; o_overflow = w_subOvf; end
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_NOR:  o_result = ~(i_a | i_b);
            OP_SLT:  o_result = {{(WIDTH-1){1'b0}}, w_lessSigned};
            OP_SLTU: o_result = {{(WIDTH-1){1'b0}}, w_lessUnsigned};
            OP_SLL,
            OP_SRL,
            OP_SRA:  o_result = i_b;
            OP_LUI:  o_result = i_b << LUI_SH;
            default: begin o_result = w_sum; o_overflow = w_addOvf; end
        endcase
    end

endmodule

// File: rtl/ula_multiciclo.sv
// ----------------------------------------------------------------------------
// ula_multiciclo
// Multi-cycle ALU for the EX stage. It executes one ALUControl operation at a
// time, using a valid/ready handshake on each side.
// Logic and arithmetic operations finish in one cycle. Shifts move the operand
// one bit per cycle through a single register, so the shifter stays small.
// The result stays held until the consumer takes it.
//   clk, rst   : clock; synchronous active-high reset
//   in_valid   : an operation and its operands are present
//   in_ready   : block can accept (only in IDLE, and only while rst is low)
//   alu_ctrl   : ALUControl code
//   a          : operand A; a[SHAMT_W-1:0] is the shift amount for shifts
//   b          : operand B; the value to shift; the immediate for LUI
//   out_valid  : result and flags are valid
//   out_ready  : consumer accepts the result
//   result     : registered result
//   zero       : registered (result == 0)
//   overflow   : registered signed overflow (ADD/SUB only)
// ----------------------------------------------------------------------------
module ula_multiciclo
    import ula_multiciclo_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int LUI_SH  = WIDTH / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    state_e             r_state;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_shReg;
    logic [SHAMT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_overflow;
    logic               r_outValid;

    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0]   w_combResult;
    logic               w_combOverflow;
    logic [WIDTH-1:0]   w_shNext;

    assign w_shamt = a[SHAMT_W-1:0];

    ula_comb #(
        .WIDTH  (WIDTH),
        .LUI_SH (LUI_SH)
    ) u_comb (
        .i_ctrl     (alu_ctrl),
        .i_a        (a),
        .i_b        (b),
        .o_result   (w_combResult),
        .o_overflow (w_combOverflow)
    );

    // One-bit step of the serial shifter. SRA copies the sign bit into the
    // vacated MSB.
    always_comb begin
        w_shNext = r_shReg >> 1;
        case (r_op)
            OP_SLL:  w_shNext = r_shReg << 1;
            OP_SRA:  w_shNext = {r_shReg[WIDTH-1], r_shReg[WIDTH-1:1]};
            default: w_shNext = r_shReg >> 1;
        endcase
    end

    // Sequencer. IDLE captures the operands. A shift with a nonzero amount
    // goes through SHIFT for exactly 'amount' cycles; every other op lands its
    // result straight into DONE. DONE holds the result until the consumer
    // accepts it. A reset at any point drops the op in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_ADD;
            r_shReg    <= '0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_overflow <= 1'b0;
            r_outValid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_op <= alu_ctrl;
                        if (isShiftOp(alu_ctrl) && (w_shamt != '0)) begin
                            r_shReg <= b;
                            r_cnt   <= w_shamt;
                            r_state <= ST_SHIFT;
                        end else begin
                            r_result   <= w_combResult;
                            r_zero     <= (w_combResult == '0);
                            r_overflow <= w_combOverflow;
                            r_outValid <= 1'b1;
                            r_state    <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_shReg <= w_shNext;
                    r_cnt   <= r_cnt - 1'b1;
                    if (r_cnt == SHAMT_W'(1)) begin
                        r_result   <= w_shNext;
                        r_zero     <= (w_shNext == '0);
                        r_overflow <= 1'b0;
                        r_outValid <= 1'b1;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_outValid <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    // in_ready is held low during reset, even though the state register
    // already reads IDLE at that point.
    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign out_valid = r_outValid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign overflow  = r_overflow;

endmodule
